// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a first-word-fall-through FIFO with registered RTS flow control.
// The receiver never stalls on a full FIFO; a byte that cannot be stored is dropped and flagged.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 104,
    parameter int DEPTH        = 16,
    parameter int RTS_MARGIN   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       rts,
    output logic [7:0] dout,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic          rx_meta;
    logic          rxs;
    logic [2:0]    state;
    logic [TW-1:0] tick;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          stop_good;
    logic          stop_bad;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          push;
    logic          pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    assign stop_good = (state == S_STOP) && (tick == '0) && rxs;
    assign stop_bad  = (state == S_STOP) && (tick == '0) && !rxs;

    // tick counts down to the next sample point; START waits half a bit to land mid-bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            tick    <= '0;
            bit_idx <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!rxs) begin
                        state <= S_START;
                        tick  <= TW'(CLKS_PER_BIT / 2 - 1);
                    end
                end
                S_START: begin
                    if (tick == '0) begin
                        if (!rxs) begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                            tick    <= TW'(CLKS_PER_BIT - 1);
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        tick <= tick - TW'(1);
                    end
                end
                S_DATA: begin
                    if (tick == '0) begin
                        tick <= TW'(CLKS_PER_BIT - 1);
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        tick <= tick - TW'(1);
                    end
                end
                S_STOP: begin
                    if (tick == '0) begin
                        state <= rxs ? S_IDLE : S_BREAK;
                    end else begin
                        tick <= tick - TW'(1);
                    end
                end
                S_BREAK: begin
                    if (rxs) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_DATA && tick == '0) begin
            shreg <= {rxs, shreg[7:1]};
        end
    end

    assign valid = (count != '0);
    assign pop   = valid && ready;
    assign push  = stop_good && ((count < CW'(DEPTH)) || pop);
    assign dout  = valid ? mem[rd_ptr] : 8'h00;

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CW'(1);
        end else if (pop && !push) begin
            count_nxt = count - CW'(1);
        end
    end

    // When full, wr_ptr == rd_ptr: a same-cycle push overwrites the slot being popped
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= shreg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rts       <= 1'b1;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count     <= count_nxt;
            rts       <= (DEPTH - int'(count_nxt)) <= RTS_MARGIN;
            frame_err <= stop_bad;
            overrun   <= stop_good && !push;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised bench for uart_rx_fifo: frames are driven bit by bit and checked against a queue model.
module tb_uart_rx_fifo;

    localparam int CPB    = 16;
    localparam int DEPTH  = 16;
    localparam int MARGIN = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       ready = 1'b0;
    logic       rts;
    logic [7:0] dout;
    logic       valid;
    logic       frame_err;
    logic       overrun;

    int total = 0;
    int bad = 0;
    int fe_seen = 0;
    int ovr_seen = 0;
    int drops = 0;
    logic [7:0] q[$];

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH), .RTS_MARGIN(MARGIN)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .rts(rts), .dout(dout),
        .valid(valid), .ready(ready), .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_seen++;
        if (overrun === 1'b1) ovr_seen++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // Drives one frame starting at the next negedge; optionally keeps the line low after the stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int tail_low);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        if (tail_low > 0) begin
            rx = 1'b0;
            repeat (tail_low) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic send_good(input logic [7:0] b);
        send_frame(b, 1'b1, 0);
        if (q.size() < DEPTH) q.push_back(b);
        else drops++;
    endtask

    task automatic drain(input string name);
        int n;
        logic [7:0] exp;
        n = q.size();
        for (int k = 0; k < n; k++) begin
            exp = q.pop_front();
            total++;
            if (valid !== 1'b1 || dout !== exp) begin
                bad++;
                $display("FAIL %s[%0d]: got valid=%b dout=%h, want valid=1 dout=%h", name, k, valid, dout, exp);
            end
            ready = 1'b1;
            @(negedge clk);
        end
        ready = 1'b0;
        total++;
        if (valid !== 1'b0) begin
            bad++;
            $display("FAIL %s_empty: got valid=%b, want 0", name, valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({rts, valid, dout, frame_err, overrun} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_outputs: got rts=%b valid=%b dout=%h fe=%b ovr=%b, want 1 0 00 0 0",
                     rts, valid, dout, frame_err, overrun);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (rts !== 1'b0) begin
            bad++;
            $display("FAIL reset_rts_release: got %b, want 0", rts);
        end
        @(negedge clk);
    endtask

    task automatic test_single();
        send_good(8'h41);
        total++;
        if (valid !== 1'b1 || dout !== 8'h41 || rts !== 1'b0) begin
            bad++;
            $display("FAIL single_0x41: got valid=%b dout=%h rts=%b, want 1 41 0", valid, dout, rts);
        end
        repeat (4) @(negedge clk);
        total++;
        if (dout !== 8'h41) begin
            bad++;
            $display("FAIL single_hold: got dout=%h, want 41", dout);
        end
        drain("single_drain");
    endtask

    task automatic test_back_to_back();
        send_good(8'h00);
        send_good(8'hFF);
        send_good(8'h55);
        send_good(8'hAA);
        drain("b2b");
    endtask

    task automatic test_fill_overrun();
        int ovr0;
        logic exp_rts;
        ovr0 = ovr_seen;
        drops = 0;
        for (int i = 1; i <= 17; i++) begin
            send_good(8'($urandom));
            exp_rts = (DEPTH - q.size()) <= MARGIN;
            total++;
            if (rts !== exp_rts) begin
                bad++;
                $display("FAIL fill_rts_byte%0d: got %b, want %b", i, rts, exp_rts);
            end
            if (i == 16) begin
                total++;
                if (ovr_seen != ovr0) begin
                    bad++;
                    $display("FAIL fill_early_overrun: got %0d pulses, want 0", ovr_seen - ovr0);
                end
            end
        end
        total++;
        if (ovr_seen - ovr0 != drops || drops != 1) begin
            bad++;
            $display("FAIL fill_overrun: got %0d pulses, want 1", ovr_seen - ovr0);
        end
        drain("fill_drain");
    endtask

    task automatic test_full_pop_same_cycle();
        int ovr0;
        logic [7:0] b17;
        for (int i = 0; i < DEPTH; i++) send_good(8'($urandom));
        ovr0 = ovr_seen;
        b17 = 8'($urandom);
        fork
            send_frame(b17, 1'b1, 0);
            begin
                @(negedge clk);
                repeat (154) @(posedge clk);
                @(negedge clk);
                ready = 1'b1;
                @(negedge clk);
                ready = 1'b0;
            end
        join
        void'(q.pop_front());
        q.push_back(b17);
        total++;
        if (ovr_seen != ovr0 || rts !== 1'b1) begin
            bad++;
            $display("FAIL fullpop: got overrun pulses=%0d rts=%b, want 0 1", ovr_seen - ovr0, rts);
        end
        drain("fullpop_drain");
    endtask

    task automatic test_frame_err();
        int fe0;
        fe0 = fe_seen;
        send_frame(8'h5A, 1'b0, 3 * CPB);
        repeat (CPB) @(negedge clk);
        total++;
        if (fe_seen - fe0 != 1 || valid !== 1'b0) begin
            bad++;
            $display("FAIL frame_err: got pulses=%0d valid=%b, want 1 0", fe_seen - fe0, valid);
        end
        send_good(8'h33);
        total++;
        if (fe_seen - fe0 != 1) begin
            bad++;
            $display("FAIL frame_err_after: got pulses=%0d, want 1", fe_seen - fe0);
        end
        drain("frame_err_recover");
    endtask

    task automatic test_glitch();
        int fe0;
        fe0 = fe_seen;
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        rx = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        total++;
        if (valid !== 1'b0 || fe_seen != fe0) begin
            bad++;
            $display("FAIL glitch: got valid=%b fe_pulses=%0d, want 0 0", valid, fe_seen - fe0);
        end
    endtask

    task automatic test_reset_midframe();
        send_good(8'hC3);
        send_good(8'h3C);
        @(negedge clk);
        rx = 1'b0;
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        q.delete();
        total++;
        if (valid !== 1'b0 || rts !== 1'b1) begin
            bad++;
            $display("FAIL midframe_reset: got valid=%b rts=%b, want 0 1", valid, rts);
        end
        rst_n = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        total++;
        if (valid !== 1'b0) begin
            bad++;
            $display("FAIL midframe_after: got valid=%b, want 0", valid);
        end
        send_good(8'h7E);
        drain("midframe_recover");
    endtask

    task automatic test_random();
        int n;
        int ovr0;
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 20);
            ovr0 = ovr_seen;
            drops = 0;
            for (int i = 0; i < n; i++) send_good(8'($urandom));
            total++;
            if (ovr_seen - ovr0 != drops) begin
                bad++;
                $display("FAIL random%0d_overrun: got %0d pulses, want %0d", r, ovr_seen - ovr0, drops);
            end
            drain($sformatf("random%0d", r));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fill_overrun();
        test_full_pop_same_cycle();
        test_frame_err();
        test_glitch();
        test_reset_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
